vscale_hasti_sram_slave: RTL and testbench

AHB-Lite (HASTI) slave that terminates one `vscale_hasti_bridge` master port (imem or dmem) with a synchronous word-organised SRAM. It accepts the pipelined address/data-phase protocol the bridge drives and supports byte, halfword and word transfers. It can insert a configurable number of wait states and returns the two-cycle ERROR response for illegal accesses. It is the memory model and FPGA block-RAM front end for `vscale_hasti_wrapper`, one instance per port.

---
 rtl/vscale_hasti_sram_slave_if.sv | 22 ++
 rtl/vscale_hasti_sram_slave.sv | 70 +++++++
 tb/tb_vscale_hasti_sram_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/vscale_hasti_sram_slave_if.sv
// vscale_hasti_sram_slave_if: AHB-Lite (HASTI) bus between a bridge port and the SRAM slave
interface vscale_hasti_sram_slave_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );
  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_sram_slave.sv
// vscale_hasti_sram_slave: HASTI slave backed by a word-organised SRAM with wait states and ERROR responses
module vscale_hasti_sram_slave #(
  parameter int NWORDS      = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic hclk,
  input logic hresetn,
  vscale_hasti_sram_slave_if.slave bus
);
  localparam int AW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [29:0] NW = 30'(NWORDS);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [AW+1:0] addr_q;
  logic write_q;
  logic [1:0] size_q;
  logic [31:0] mem [NWORDS];
  logic sample, legal, unused;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign unused = ^{bus.hburst, bus.hmastlock, bus.hprot};
  assign sample = bus.hready && bus.htrans[1];
  assign legal = bus.hsize <= 3'd2 && !(bus.hsize == 3'd1 && bus.haddr[0])
              && !(bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00) && bus.haddr[31:2] < NW;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_WAIT: begin
        state_n = cnt == 2'd1 ? S_DATA : S_WAIT;
        cnt_n = cnt - 2'd1;
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        state_n = !sample ? S_IDLE : !legal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
        cnt_n = sample && legal ? 2'(WAIT_STATES) : 2'd0;
      end
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt <= 2'd0;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= 2'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (sample) begin
        addr_q <= bus.haddr[AW+1:0];
        write_q <= bus.hwrite;
        size_q <= bus.hsize[1:0];
      end
    end
  end
  assign idx = addr_q[AW+1:2];
  assign be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0]
            : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Lanes map straight through: hwdata is already lane-aligned by the master
  always_ff @(posedge hclk) begin
    if (state == S_DATA && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
  end
  assign bus.hrdata = state == S_DATA && !write_q ? mem[idx] : 32'd0;
  assign bus.hready = !(state == S_WAIT || state == S_ERR1);
  assign bus.hresp  = state == S_ERR1 || state == S_ERR2;
endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// tb_vscale_hasti_sram_slave: table-driven scoreboard bench over three wait-state configurations
module tb_vscale_hasti_sram_slave;
  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  logic hclk, hresetn;
  logic [31:0] haddr, hwdata;
  logic hwrite;
  logic [2:0] hsize;
  logic [1:0] htrans;
  int sel;
  int n_checks = 0, n_fail = 0;
  int ws_of[3] = '{0, 2, 3};
  logic [31:0] o_hrdata;
  logic o_hready, o_hresp;

  vscale_hasti_sram_slave_if if0 ();
  vscale_hasti_sram_slave_if if1 ();
  vscale_hasti_sram_slave_if if2 ();

  assign if0.haddr = haddr;  assign if1.haddr = haddr;  assign if2.haddr = haddr;
  assign if0.hwrite = hwrite; assign if1.hwrite = hwrite; assign if2.hwrite = hwrite;
  assign if0.hsize = hsize;  assign if1.hsize = hsize;  assign if2.hsize = hsize;
  assign if0.hwdata = hwdata; assign if1.hwdata = hwdata; assign if2.hwdata = hwdata;
  assign if0.hburst = 3'd0;  assign if1.hburst = 3'd0;  assign if2.hburst = 3'd0;
  assign if0.hmastlock = 1'b0; assign if1.hmastlock = 1'b0; assign if2.hmastlock = 1'b0;
  assign if0.hprot = 4'd0;   assign if1.hprot = 4'd0;   assign if2.hprot = 4'd0;
  assign if0.htrans = sel == 0 ? htrans : 2'b00;
  assign if1.htrans = sel == 1 ? htrans : 2'b00;
  assign if2.htrans = sel == 2 ? htrans : 2'b00;
  assign o_hready = sel == 0 ? if0.hready : sel == 1 ? if1.hready : if2.hready;
  assign o_hresp  = sel == 0 ? if0.hresp  : sel == 1 ? if1.hresp  : if2.hresp;
  assign o_hrdata = sel == 0 ? if0.hrdata : sel == 1 ? if1.hrdata : if2.hrdata;

  vscale_hasti_sram_slave #(.NWORDS(64), .WAIT_STATES(0)) u_ws0 (.hclk(hclk), .hresetn(hresetn), .bus(if0.slave));
  vscale_hasti_sram_slave #(.NWORDS(64), .WAIT_STATES(2)) u_ws2 (.hclk(hclk), .hresetn(hresetn), .bus(if1.slave));
  vscale_hasti_sram_slave #(.NWORDS(64), .WAIT_STATES(3)) u_ws3 (.hclk(hclk), .hresetn(hresetn), .bus(if2.slave));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t wr_v(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    return '{tr: 2'd2, wr: 1'b1, sz: sz, a: a, wd: wd, err: 1'b0, rd: 32'd0};
  endfunction
  function automatic vec_t rd_v(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
    return '{tr: 2'd2, wr: 1'b0, sz: sz, a: a, wd: 32'd0, err: 1'b0, rd: rd};
  endfunction
  function automatic vec_t er_v(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    return '{tr: 2'd2, wr: wr, sz: sz, a: a, wd: 32'hFFFFFFFF, err: 1'b1, rd: 32'd0};
  endfunction
  function automatic vec_t id_v(input logic [1:0] tr);
    return '{tr: tr, wr: 1'b0, sz: 3'd2, a: 32'h10, wd: 32'd0, err: 1'b0, rd: 32'd0};
  endfunction

  // Drives the vectors back to back; expected data phases queue up when the address is accepted
  task automatic run(input int s, input vec_t tv[$]);
    vec_t q[$];
    vec_t cur;
    int i = 0, waits = 0;
    sel = s;
    for (int cyc = 0; cyc < 20 * (tv.size() + 2) && (i < tv.size() || q.size() > 0); cyc++) begin
      @(posedge hclk);
      #1;
      htrans = i < tv.size() ? tv[i].tr : 2'b00;
      hwrite = i < tv.size() ? tv[i].wr : 1'b0;
      hsize  = i < tv.size() ? tv[i].sz : 3'd2;
      haddr  = i < tv.size() ? tv[i].a : 32'd0;
      hwdata = q.size() > 0 ? q[0].wd : 32'd0;
      @(negedge hclk);
      if (q.size() == 0) begin
        chk("idle_hready", 32'(o_hready), 32'd1);
        chk("idle_hresp", 32'(o_hresp), 32'd0);
      end else if (!o_hready) begin
        waits++;
        chk("stall_hresp", 32'(o_hresp), 32'(q[0].err));
        chk("stall_hrdata", o_hrdata, 32'd0);
      end else begin
        cur = q.pop_front();
        chk($sformatf("hresp@%h", cur.a), 32'(o_hresp), 32'(cur.err));
        chk($sformatf("hrdata@%h", cur.a), o_hrdata, cur.rd);
        chk($sformatf("waits@%h", cur.a), 32'(waits), cur.err ? 32'd1 : 32'(ws_of[s]));
        waits = 0;
      end
      if (o_hready && i < tv.size()) begin
        if (tv[i].tr[1]) q.push_back(tv[i]);
        i++;
      end
    end
    if (i < tv.size() || q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got %0d pending expected 0", q.size() + tv.size() - i);
    end
    @(posedge hclk);
    #1;
    htrans = 2'b00;
  endtask

  initial begin
    vec_t t0[$], t0b[$], t2[$], t3[$], t3b[$];
    t0.push_back(id_v(2'd0));
    t0.push_back(wr_v(3'd2, 32'h10, 32'hDEADBEEF));
    t0.push_back(rd_v(3'd2, 32'h10, 32'hDEADBEEF));
    t0.push_back(id_v(2'd1));
    t0.push_back(wr_v(3'd2, 32'h10, 32'h00000000));
    t0.push_back(wr_v(3'd0, 32'h13, 32'hAA000000));
    t0.push_back(wr_v(3'd1, 32'h10, 32'h00001234));
    t0.push_back(rd_v(3'd2, 32'h10, 32'hAA001234));
    t0.push_back(rd_v(3'd0, 32'h13, 32'hAA001234));
    t0.push_back(wr_v(3'd1, 32'h12, 32'hBEEF0000));
    t0.push_back(wr_v(3'd0, 32'h11, 32'h00005600));
    t0.push_back(rd_v(3'd2, 32'h10, 32'hBEEF5634));
    t0.push_back(wr_v(3'd2, 32'h00, 32'h01020304));
    t0.push_back(wr_v(3'd2, 32'h20, 32'h600DF00D));
    t0.push_back(er_v(1'b1, 3'd2, 32'h02));
    t0.push_back(er_v(1'b1, 3'd1, 32'h01));
    t0.push_back(er_v(1'b1, 3'd3, 32'h00));
    t0.push_back(er_v(1'b1, 3'd2, 32'h100));
    t0.push_back(er_v(1'b0, 3'd2, 32'h100));
    t0.push_back(rd_v(3'd2, 32'h00, 32'h01020304));
    t0.push_back(wr_v(3'd2, 32'hFC, 32'hCAFEF00D));
    t0.push_back(rd_v(3'd2, 32'hFC, 32'hCAFEF00D));
    t0b.push_back(rd_v(3'd2, 32'h20, 32'h600DF00D));
    t2.push_back(wr_v(3'd2, 32'h08, 32'h5A5A5A5A));
    t2.push_back(rd_v(3'd2, 32'h08, 32'h5A5A5A5A));
    t2.push_back(wr_v(3'd0, 32'h08, 32'h000000C3));
    t2.push_back(rd_v(3'd2, 32'h08, 32'h5A5A5AC3));
    t2.push_back(er_v(1'b1, 3'd2, 32'h06));
    t2.push_back(rd_v(3'd2, 32'h08, 32'h5A5A5AC3));
    t3.push_back(wr_v(3'd2, 32'h40, 32'h11111111));
    t3.push_back(rd_v(3'd2, 32'h40, 32'h11111111));
    t3b.push_back(rd_v(3'd2, 32'h40, 32'h11111111));

    sel = 0;
    hresetn = 1'b0;
    htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'd0; hwdata = 32'd0;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_hready", 32'(o_hready), 32'd1);
      chk("rst_hresp", 32'(o_hresp), 32'd0);
      chk("rst_hrdata", o_hrdata, 32'd0);
    end
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;

    run(0, t0);

    // NONSEQ write offered during ERR1 must be ignored
    @(posedge hclk); #1;
    htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h22;
    @(posedge hclk); #1;
    haddr = 32'h20;
    @(negedge hclk);
    chk("err1_hready", 32'(o_hready), 32'd0);
    chk("err1_hresp", 32'(o_hresp), 32'd1);
    @(posedge hclk); #1;
    htrans = 2'd0; hwdata = 32'hBAD0BAD0;
    @(negedge hclk);
    chk("err2_hready", 32'(o_hready), 32'd1);
    chk("err2_hresp", 32'(o_hresp), 32'd1);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("post_err_hresp", 32'(o_hresp), 32'd0);
    chk("post_err_hready", 32'(o_hready), 32'd1);
    run(0, t0b);

    run(1, t2);

    run(2, t3);
    // Reset while a write is stalled in wait states
    @(posedge hclk); #1;
    htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge hclk); #1;
    htrans = 2'd0; hwdata = 32'h22222222;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("ws3_wait_hready", 32'(o_hready), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("async_rst_hready", 32'(o_hready), 32'd1);
    chk("async_rst_hresp", 32'(o_hresp), 32'd0);
    chk("async_rst_hrdata", o_hrdata, 32'd0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    run(2, t3b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
